// File: rtl/goertzel_power_if.sv
// Handshake bundle between the Goertzel resonator and its magnitude-squared stage.
// The resonator (or the bench) drives the master side; goertzel_power is the slave.
interface goertzel_power_if #(
    parameter int IW = 32
);
    logic                   i_valid;
    logic signed [IW-1:0]   i_s1;
    logic signed [IW-1:0]   i_s2;
    logic [2*IW-1:0]        i_thresh;
    logic [2*IW-1:0]        o_power;
    logic                   o_valid;
    logic                   o_detect;
    logic                   o_busy;
    logic                   o_overrun;

    modport master (
        output i_valid, i_s1, i_s2, i_thresh,
        input  o_power, o_valid, o_detect, o_busy, o_overrun
    );

    modport slave (
        input  i_valid, i_s1, i_s2, i_thresh,
        output o_power, o_valid, o_detect, o_busy, o_overrun
    );
endinterface

// File: rtl/goertzel_power.sv
// Goertzel bin power P = s1^2 + s2^2 - s1*s2 (coefficient 1), computed with a
// single shared signed multiplier over three cycles, then thresholded.
//
// state | meaning
// IDLE  | waiting for i_valid; operands captured on acceptance
// SQ1   | acc <= s1*s1
// SQ2   | acc <= acc + s2*s2
// CROSS | result <= acc - s1*s2, detect compare, o_valid pulse
module goertzel_power #(
    parameter int IW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    goertzel_power_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SQ1, SQ2, CROSS} state_t;

    state_t                 state;
    state_t                 state_next;

    logic signed [IW-1:0]   op_s1;
    logic signed [IW-1:0]   op_s2;
    logic signed [IW-1:0]   mul_a;
    logic signed [IW-1:0]   mul_b;
    logic signed [2*IW-1:0] product;
    logic signed [2*IW:0]   acc;
    logic [2*IW-1:0]        result;

    logic [2*IW-1:0]        power_q;
    logic                   valid_q;
    logic                   detect_q;
    logic                   overrun_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_valid) state_next = SQ1;
            SQ1:     state_next = SQ2;
            SQ2:     state_next = CROSS;
            CROSS:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One product per cycle; operand pairing follows the state.
    always_comb begin
        mul_a = op_s1;
        mul_b = op_s1;
        case (state)
            SQ2:     begin mul_a = op_s2; mul_b = op_s2; end
            CROSS:   begin mul_a = op_s1; mul_b = op_s2; end
            default: begin mul_a = op_s1; mul_b = op_s1; end
        endcase
    end

    assign product = mul_a * mul_b;

    // P is non-negative and fits in 2*IW bits, so modular low-half arithmetic is exact.
    assign result = acc[2*IW-1:0] - $unsigned(product);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_s1     <= '0;
            op_s2     <= '0;
            acc       <= '0;
            power_q   <= '0;
            valid_q   <= 1'b0;
            detect_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= bus.i_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        op_s1 <= bus.i_s1;
                        op_s2 <= bus.i_s2;
                    end
                end
                SQ1:   acc <= {product[2*IW-1], product};
                SQ2:   acc <= acc + {product[2*IW-1], product};
                CROSS: begin
                    power_q  <= result;
                    detect_q <= (result > bus.i_thresh);
                    valid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_power   = power_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_detect  = detect_q;
    assign bus.o_overrun = overrun_q;
    assign bus.o_busy    = (state != IDLE);
endmodule

// File: tb/tb_goertzel_power.sv
// Directed bench for goertzel_power: expected results are queued at stimulus time
// and matched (value, detect flag, arrival cycle) when o_valid appears.
module tb_goertzel_power;
    typedef struct {
        logic [63:0] power;
        logic        detect;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ovr_a = 0;
    int   ovr_before;
    exp_t qa[$];
    exp_t qb[$];

    goertzel_power_if #(.IW(32)) bus_a ();
    goertzel_power_if #(.IW(8))  bus_b ();

    goertzel_power #(.IW(32)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    goertzel_power #(.IW(8))  dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [63:0] p, input logic d);
        exp_t e;
        e.power = p; e.detect = d; e.due = cyc + 4;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [63:0] p, input logic d);
        exp_t e;
        e.power = p; e.detect = d; e.due = cyc + 4;
        qb.push_back(e);
    endtask

    task automatic drive_a(input int s1, input int s2, input logic [63:0] th);
        bus_a.i_valid  = 1'b1;
        bus_a.i_s1     = s1;
        bus_a.i_s2     = s2;
        bus_a.i_thresh = th;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Result monitors: every o_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus_a.o_overrun) ovr_a++;
        if (bus_a.o_valid) begin
            n_cmp++;
            assert (qa.size() > 0) else begin
                n_err++;
                $error("FAIL a_unexpected_valid observed=%0d expected=none", bus_a.o_power);
            end
            if (qa.size() > 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_power", bus_a.o_power, e.power);
                chk("a_detect", 64'(bus_a.o_detect), 64'(e.detect));
                chk("a_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (bus_b.o_valid) begin
            n_cmp++;
            assert (qb.size() > 0) else begin
                n_err++;
                $error("FAIL b_unexpected_valid observed=%0d expected=none", bus_b.o_power);
            end
            if (qb.size() > 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_power", 64'(bus_b.o_power), e.power);
                chk("b_detect", 64'(bus_b.o_detect), 64'(e.detect));
                chk("b_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        bus_a.i_valid = 1'b0; bus_a.i_s1 = '0; bus_a.i_s2 = '0; bus_a.i_thresh = '0;
        bus_b.i_valid = 1'b0; bus_b.i_s1 = '0; bus_b.i_s2 = '0; bus_b.i_thresh = '0;
        idle_cycles(3);
        chk("rst_power", bus_a.o_power, 64'd0);
        chk("rst_valid", 64'(bus_a.o_valid), 64'd0);
        chk("rst_detect", 64'(bus_a.o_detect), 64'd0);
        chk("rst_busy", 64'(bus_a.o_busy), 64'd0);
        chk("rst_overrun", 64'(bus_a.o_overrun), 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Basic: 9 + 25 - 15 = 19, below threshold 100
        drive_a(3, 5, 64'd100); push_a(64'd19, 1'b0);
        @(negedge clk); bus_a.i_valid = 1'b0;
        chk("busy_t0", 64'(bus_a.o_busy), 64'd1);
        @(negedge clk); chk("busy_t1", 64'(bus_a.o_busy), 64'd1);
        @(negedge clk); chk("busy_t2", 64'(bus_a.o_busy), 64'd1);
        @(negedge clk); chk("busy_t3", 64'(bus_a.o_busy), 64'd0);
        chk("valid_t3", 64'(bus_a.o_valid), 64'd1);
        @(negedge clk); chk("valid_pulse_end", 64'(bus_a.o_valid), 64'd0);
        idle_cycles(2);

        // Back-to-back: second input offered in the first result's o_valid cycle
        ovr_before = ovr_a;
        drive_a(-4, 4, 64'd20); push_a(64'd48, 1'b1);
        @(negedge clk); bus_a.i_valid = 1'b0;
        idle_cycles(3);
        chk("b2b_first_valid", 64'(bus_a.o_valid), 64'd1);
        drive_a(5, 1, 64'd20); push_a(64'd21, 1'b1);
        @(negedge clk); bus_a.i_valid = 1'b0;
        chk("b2b_accepted_busy", 64'(bus_a.o_busy), 64'd1);
        idle_cycles(4);
        chk("b2b_no_overrun", 64'(ovr_a), 64'(ovr_before));

        // Narrow instance extremes: no wrap in the 16-bit result
        bus_b.i_valid = 1'b1; bus_b.i_s1 = -8'sd128; bus_b.i_s2 = 8'sd127; bus_b.i_thresh = 16'd0;
        push_b(64'd48769, 1'b1);
        @(negedge clk); bus_b.i_valid = 1'b0;
        idle_cycles(3);
        bus_b.i_valid = 1'b1; bus_b.i_s1 = -8'sd128; bus_b.i_s2 = -8'sd128; bus_b.i_thresh = 16'd20000;
        push_b(64'd16384, 1'b0);
        @(negedge clk); bus_b.i_valid = 1'b0;
        idle_cycles(5);

        // Overrun: second strobe lands while in SQ1 and must be dropped
        ovr_before = ovr_a;
        drive_a(3, 0, 64'd100); push_a(64'd9, 1'b0);
        @(negedge clk); drive_a(7, 7, 64'd100);
        @(negedge clk); bus_a.i_valid = 1'b0;
        chk("overrun_pulse", 64'(bus_a.o_overrun), 64'd1);
        @(negedge clk); chk("overrun_one_cycle", 64'(bus_a.o_overrun), 64'd0);
        idle_cycles(5);
        chk("overrun_count", 64'(ovr_a), 64'(ovr_before + 1));

        // Reset during SQ2 discards the computation
        drive_a(9, 9, 64'd0);
        @(negedge clk); bus_a.i_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(bus_a.o_busy), 64'd0);
        chk("midrst_power", bus_a.o_power, 64'd0);
        chk("midrst_valid", 64'(bus_a.o_valid), 64'd0);
        chk("midrst_detect", 64'(bus_a.o_detect), 64'd0);
        chk("midrst_overrun", 64'(bus_a.o_overrun), 64'd0);
        rst = 1'b0;
        idle_cycles(4);
        drive_a(2, 1, 64'd100); push_a(64'd3, 1'b0);
        @(negedge clk); bus_a.i_valid = 1'b0;
        idle_cycles(5);

        // Reset wins over a simultaneous strobe
        rst = 1'b1; drive_a(6, 6, 64'd0);
        @(negedge clk); rst = 1'b0; bus_a.i_valid = 1'b0;
        chk("rstvalid_busy", 64'(bus_a.o_busy), 64'd0);
        chk("rstvalid_overrun", 64'(bus_a.o_overrun), 64'd0);
        @(negedge clk); chk("rstvalid_still_idle", 64'(bus_a.o_busy), 64'd0);
        idle_cycles(5);

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        chk("a_outstanding", 64'(qa.size()), 64'd0);
        chk("b_outstanding", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/goertzel_power.md
# goertzel_power

Magnitude-squared stage placed directly downstream of the Goertzel IIR resonator (k/N = 1/6, so 2cos(2πk/N) = 1). Once per block it accepts the resonator's final state pair s1 = s[N-1] and s2 = s[N-2] and computes the bin power P = s1² + s2² − s1·s2. It does this with one shared signed multiplier sequenced by a small FSM. It registers P, flags it against a runtime threshold, and reports dropped inputs.

## Interface
- IW, 32, width of signed s1/s2 inputs (matches resonator state width)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset: synchronous, active-high
- i_valid  in  1  one-cycle strobe; i_s1/i_s2 valid this cycle
- i_s1  in  IW  signed s[N-1]
- i_s2  in  IW  signed s[N-2]
- i_thresh  in  2*IW  unsigned detection threshold, sampled when the result is written
- o_power  out  2*IW  unsigned P, held until next result
- o_valid  out  1  one-cycle pulse, o_power/o_detect updated this cycle
- o_detect  out  1  (P > i_thresh), held with o_power
- o_busy  out  1  high while a computation is in flight (inputs not accepted)
- o_overrun  out  1  one-cycle pulse: an i_valid was dropped

## Operation
- FSM states: IDLE, SQ1, SQ2, CROSS.
  - IDLE: on i_valid, capture i_s1/i_s2 into operand registers and go to SQ1.
  - SQ1: acc <= s1·s1; go to SQ2.
  - SQ2: acc <= acc + s2·s2; go to CROSS.
  - CROSS: o_power <= acc − s1·s2; o_detect <= (result > i_thresh); o_valid <= 1; go to IDLE.
- Single IW×IW signed multiplier. Its operands are muxed by state (s1,s1 / s2,s2 / s1,s2). Only one product is formed per cycle.
- Width rules:
  - Product: 2*IW signed.
  - acc: 2*IW+1 bits signed, sign-extending every product.
  - P is mathematically ≥ 0 and ≤ 3·2^(2IW−2), so the low 2*IW bits of the final sum are exact. o_power is those bits, unsigned.
  - No saturation or rounding.
- o_busy = (state != IDLE).
- i_valid in any non-IDLE state: the input is ignored, the in-flight result is unaffected, and o_overrun pulses on the next cycle.
- Reset, mid-operation included: state IDLE, acc/operands 0, o_power 0, o_valid 0, o_detect 0, o_busy 0, o_overrun 0. No partial result is emitted.
- i_rst has priority over i_valid in the same cycle.

## Timing
- Edge T0 samples i_valid=1 in IDLE. The FSM passes through SQ1 (T1) and SQ2 (T2) and reaches CROSS (T3).
- o_valid is high for exactly one cycle, between edges T3 and T4. Latency is 4 edges from the accepting edge to o_valid.
- o_busy is high from after T0 to after T3. The cycle in which o_valid is high is IDLE, so a new i_valid there is accepted. Maximum throughput is one input every 4 cycles; the resonator delivers one per N cycles.
- o_overrun is registered: high in the cycle after the rejected i_valid edge.
- i_thresh is sampled at edge T3 only.

## Test plan
- Reset, then s1=3, s2=5 at T0 with thresh=100 -> o_valid pulse after T3; o_power=19, o_detect=0; o_busy high for cycles T0+..T3.
- s1=−4, s2=4, then s1=5, s2=1 back-to-back, second i_valid presented in the first result's o_valid cycle, thresh=20 -> results 48 (detect 1) then 21 (detect 1), 4 cycles apart, no overrun.
- IW=8, s1=−128, s2=127 -> o_power=48769 (16-bit, no wrap); s1=s2=−128 -> 16384.
- i_valid at T0 (s1=3, s2=0), second i_valid at T1 (s1=7, s2=7) -> o_overrun pulse after T1; o_power=9; only one o_valid.
- i_rst asserted during SQ2 -> no o_valid; all outputs 0 next cycle; a following input s1=2, s2=1 yields 3 with normal latency.
- i_rst and i_valid in the same cycle -> input dropped, FSM stays IDLE, o_overrun stays 0.
